uart_rx: RTL and testbench

//   Serial receive end of the UART link: deserializes the 8N1 stream produced by the UART transmitter

---
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
//==============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with 2-flop input sync, mid-bit sampling,
//            stop-bit check and break suppression.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] c_half     = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_last     = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] c_idx_last = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [CW-1:0]        r_bit_cnt;
    logic [CW-1:0]        w_bit_cnt_n;
    logic [IW-1:0]        r_bit_idx;
    logic [IW-1:0]        w_bit_idx_n;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] w_shreg_n;
    logic [DATA_BITS-1:0] r_rx_data;
    logic [DATA_BITS-1:0] w_rx_data_n;
    logic                 r_rx_valid;
    logic                 w_rx_valid_n;
    logic                 r_frame_err;
    logic                 w_frame_err_n;
    logic                 w_rx_s;

    // Sync flops reset to the idle (high) line level so reset release is not a start bit.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_bit_cnt   <= w_bit_cnt_n;
            r_bit_idx   <= w_bit_idx_n;
            r_shreg     <= w_shreg_n;
            r_rx_data   <= w_rx_data_n;
            r_rx_valid  <= w_rx_valid_n;
            r_frame_err <= w_frame_err_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_bit_cnt_n   = r_bit_cnt + CW'(1);
        w_bit_idx_n   = r_bit_idx;
        w_shreg_n     = r_shreg;
        w_rx_data_n   = r_rx_data;
        w_rx_valid_n  = 1'b0;
        w_frame_err_n = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_bit_cnt_n = '0;
                if (!w_rx_s) begin
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (r_bit_cnt == c_half) begin
                    w_bit_cnt_n = '0;
                    w_bit_idx_n = '0;
                    w_state_n   = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_bit_cnt == c_last) begin
                    w_bit_cnt_n = '0;
                    w_shreg_n   = {w_rx_s, r_shreg[DATA_BITS-1:1]};
                    if (r_bit_idx == c_idx_last) begin
                        w_state_n = S_STOP;
                    end else begin
                        w_bit_idx_n = r_bit_idx + IW'(1);
                    end
                end
            end
            S_STOP: begin
                // Leaving at the stop-bit midpoint leaves half a bit to catch a back-to-back start.
                if (r_bit_cnt == c_last) begin
                    w_bit_cnt_n = '0;
                    if (w_rx_s) begin
                        w_rx_data_n  = r_shreg;
                        w_rx_valid_n = 1'b1;
                        w_state_n    = S_IDLE;
                    end else begin
                        w_frame_err_n = 1'b1;
                        w_state_n     = S_BRK;
                    end
                end
            end
            S_BRK: begin
                w_bit_cnt_n = '0;
                if (w_rx_s) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_bit_cnt_n = '0;
                w_state_n   = S_IDLE;
            end
        endcase
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//==============================================================================
// Module   : tb_uart_rx
// Brief    : Scoreboard bench for uart_rx driven by a behavioural 8N1 transmitter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int DW      = 8;
    localparam int CLK_PER = 10;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          clr;
    logic          rx;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          busy;

    exp_t          sb_q[$];
    exp_t          e;
    logic [DW-1:0] last_good;
    int            n_tests;
    int            n_fail;
    logic          prev_out;
    logic          saw_busy;
    logic          lat_en;
    time           t_fall;
    int            lat;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DW)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #(CLK_PER / 2) clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic err, input logic [DW-1:0] d);
        exp_t x;
        x.err  = err;
        x.data = err ? last_good : d;
        sb_q.push_back(x);
        if (!err) last_good = d;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop);
        @(negedge clk);
        rx     = 1'b0;
        t_fall = $time;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            @(negedge clk);
            rx = d[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx = stop;
        repeat (CPB - 1) @(negedge clk);
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (busy) saw_busy = 1'b1;
        if (rx_valid || frame_err) begin
            check_eq("valid_err_excl", 32'(rx_valid & frame_err), 32'd0);
            check_eq("pulse_width", 32'(prev_out), 32'd0);
            if (sb_q.size() == 0) begin
                check_eq("unexpected_output", 32'({rx_valid, frame_err}), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("kind_frame_err", 32'(frame_err), 32'(e.err));
                check_eq("rx_data", 32'(rx_data), 32'(e.data));
                if (lat_en && rx_valid) begin
                    lat    = int'(($time - t_fall) / CLK_PER);
                    lat_en = 1'b0;
                    check_eq("latency_in_range", 32'((lat >= 154) && (lat <= 156)), 32'd1);
                end
            end
        end
        prev_out = rx_valid | frame_err;
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] c3;
        n_tests   = 0;
        n_fail    = 0;
        prev_out  = 1'b0;
        saw_busy  = 1'b0;
        lat_en    = 1'b0;
        last_good = '0;
        t_fall    = 0;
        rx        = 1'b1;
        clr       = 1'b0;

        // 1: reset values, single frame, busy window, latency
        idle(5);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        clr = 1'b1;
        idle(20);
        check_eq("idle_busy", 32'(busy), 32'd0);
        push_exp(1'b0, 8'hA5);
        lat_en = 1'b1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                idle(80);
                check_eq("busy_mid_frame", 32'(busy), 32'd1);
            end
        join
        idle(40);
        check_eq("busy_after_frame", 32'(busy), 32'd0);
        check_eq("lat_measured", 32'(lat_en), 32'd0);
        check_eq("sb_drain_t1", 32'(sb_q.size()), 32'd0);

        // 2: back-to-back frames
        push_exp(1'b0, 8'h00);
        push_exp(1'b0, 8'hFF);
        push_exp(1'b0, 8'h81);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        idle(40);
        check_eq("sb_drain_t2", 32'(sb_q.size()), 32'd0);
        check_eq("rx_data_hold_t2", 32'(rx_data), 32'h81);

        // 3: short glitch is rejected
        saw_busy = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(10);
        check_eq("glitch_saw_busy", 32'(saw_busy), 32'd1);
        check_eq("glitch_back_idle", 32'(busy), 32'd0);
        idle(30);
        check_eq("rx_data_hold_t3", 32'(rx_data), 32'h81);

        // 4: framing error, break, recovery
        push_exp(1'b1, 8'h5A);
        send_frame(8'h5A, 1'b0);
        idle(40);
        check_eq("brk_busy", 32'(busy), 32'd1);
        rx = 1'b1;
        idle(32);
        check_eq("rx_data_after_err", 32'(rx_data), 32'h81);
        push_exp(1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1);
        idle(40);
        check_eq("sb_drain_t4", 32'(sb_q.size()), 32'd0);

        // 5: reset during bit 4 of 0xC3
        c3 = 8'hC3;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx = c3[i];
            repeat (CPB - 1) @(negedge clk);
        end
        idle(2);
        clr = 1'b0;
        idle(3);
        check_eq("midrst_rx_data", 32'(rx_data), 32'd0);
        check_eq("midrst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("midrst_frame_err", 32'(frame_err), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        idle(4);
        clr       = 1'b1;
        last_good = '0;
        idle(32);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        push_exp(1'b0, 8'h12);
        send_frame(8'h12, 1'b1);
        idle(40);
        check_eq("sb_drain_t5", 32'(sb_q.size()), 32'd0);

        // 6: random loopback with reset between words
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            clr = 1'b0;
            idle(2);
            clr       = 1'b1;
            last_good = '0;
            idle(4);
            w = DW'($urandom_range(0, 255));
            push_exp(1'b0, w);
            send_frame(w, 1'b1);
            idle(8);
        end
        idle(40);
        check_eq("sb_drain_t6", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
